// File: rtl/estimador_ctrl_pkg.sv
// rtl/estimador_ctrl_pkg.sv - shared types and defaults for the estimador kernel controller
package estimador_ctrl_pkg;
  localparam int N_LANES     = 3;
  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/estimador_vld_capture.sv
// rtl/estimador_vld_capture.sv - one result lane: data register plus seen flag
module estimador_vld_capture
  import estimador_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         cap,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         seen
);

  logic [W-1:0] data_q, data_d;
  logic         seen_q, seen_d;

  // Clear wins: a new operand pair always starts from an empty lane.
  always_comb begin
    data_d = data_q;
    seen_d = seen_q;
    if (clr) begin
      data_d = '0;
      seen_d = 1'b0;
    end else if (cap) begin
      data_d = d;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      seen_q <= 1'b0;
    end else begin
      data_q <= data_d;
      seen_q <= seen_d;
    end
  end

  assign q    = data_q;
  assign seen = seen_q;
endmodule

// File: rtl/estimador_vadd_row3_ctrl.sv
// rtl/estimador_vadd_row3_ctrl.sv - start/done initiator for the 3-lane saturating vadd kernel
module estimador_vadd_row3_ctrl
  import estimador_ctrl_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_LANES*W-1:0] in_a,
  input  logic [N_LANES*W-1:0] in_b,
  output logic                 k_start,
  input  logic                 k_ready,
  input  logic                 k_done,
  input  logic                 k_idle,
  output logic [N_LANES*W-1:0] k_a,
  output logic [N_LANES*W-1:0] k_b,
  input  logic [N_LANES*W-1:0] k_y,
  input  logic [N_LANES-1:0]   k_y_vld,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_LANES*W-1:0] out_y,
  output logic                 out_err,
  output logic                 busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_LANES*W-1:0] ka_q, ka_d, kb_q, kb_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic [N_LANES-1:0]   seen, cap_en;
  logic [N_LANES*W-1:0] y_reg;

  assign accept = in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ka_d    = in_a;
          kb_d    = in_b;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Lanes whose vld coincides with done still count as delivered.
        if (k_done) begin
          err_d   = ~&(seen | k_y_vld);
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign cap_en[i] = (state_q == ST_RUN) && k_y_vld[i];
    estimador_vld_capture #(.W(W)) u_cap (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .clr   (accept),
      .cap   (cap_en[i]),
      .d     (k_y[i*W +: W]),
      .q     (y_reg[i*W +: W]),
      .seen  (seen[i])
    );
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign k_start   = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_RESP);
  assign out_err   = err_q && out_valid;
  assign out_y     = err_q ? '0 : y_reg;
  assign k_a       = ka_q;
  assign k_b       = kb_q;

  // Kernel-side protocol checks; k_ready and k_idle feed nothing else.
  a_ready_in_run: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    k_ready |-> k_start);
  a_idle_not_done: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    k_idle |-> !k_done);
endmodule
